// File: rtl/mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu                                                                  |
// | Memory-access stage: sized loads/stores on a single-outstanding bus.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [31:0]           ex_wdata,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_reg_write,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata,
    output logic                  mem_unpause_signal,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  misalign,
    output logic                  bus_err,
    output logic                  busy
);

    localparam int                 C_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    consumed_q, consumed_d;
    logic [C_CNT_W-1:0]      tmo_q, tmo_d;
    logic                    is_load_q, is_load_d;
    logic [1:0]              lane_q, lane_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [4:0]              rd_q, rd_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]             bus_wdata_q, bus_wdata_d;
    logic [3:0]              bus_wstrb_q, bus_wstrb_d;
    logic                    unpause_q, unpause_d;
    logic                    wb_valid_q, wb_valid_d;
    logic                    wb_we_q, wb_we_d;
    logic [4:0]              wb_rd_q, wb_rd_d;
    logic [31:0]             wb_data_q, wb_data_d;
    logic                    misalign_q, misalign_d;
    logic                    bus_err_q, bus_err_d;

    logic        w_mem_op, w_capture, w_misaligned;
    logic        w_is_byte, w_is_half, w_is_word;
    logic [31:0] w_st_wdata, w_alu_result, w_rd_shift, w_load;
    logic [3:0]  w_st_wstrb;

    // Non-memory ops forward the ALU result as writeback data.
    if (ADDR_WIDTH >= 32) begin : g_alu_trunc
        assign w_alu_result = ex_addr[31:0];
    end else begin : g_alu_ext
        assign w_alu_result = {{(32-ADDR_WIDTH){1'b0}}, ex_addr};
    end

    assign w_mem_op     = ex_mem_read | ex_mem_write;
    assign w_capture    = (state_q == IDLE) && ex_valid && w_mem_op && !consumed_q;
    assign w_is_byte    = (ex_funct3[1:0] == 2'b00);
    assign w_is_half    = (ex_funct3[1:0] == 2'b01);
    assign w_is_word    = !w_is_byte && !w_is_half;
    assign w_misaligned = (w_is_half && ex_addr[0]) || (w_is_word && (ex_addr[1:0] != 2'b00));

    always_comb begin
        w_st_wdata = ex_wdata;
        w_st_wstrb = 4'b1111;
        if (w_is_byte) begin
            w_st_wdata = {4{ex_wdata[7:0]}};
            w_st_wstrb = 4'b0001 << ex_addr[1:0];
        end else if (w_is_half) begin
            w_st_wdata = {2{ex_wdata[15:0]}};
            w_st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
        end
        if (!ex_mem_write) begin
            w_st_wstrb = 4'b0000;
        end
    end

    // Read lane selection uses the offset latched at capture, not the live EX/MEM address.
    assign w_rd_shift = bus_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   w_load = {{24{w_rd_shift[7] & ~funct3_q[2]}}, w_rd_shift[7:0]};
            2'b01:   w_load = {{16{w_rd_shift[15] & ~funct3_q[2]}}, w_rd_shift[15:0]};
            default: w_load = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        consumed_d  = pause ? consumed_q : 1'b0;
        tmo_d       = '0;
        is_load_d   = is_load_q;
        lane_d      = lane_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        unpause_d   = 1'b0;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_capture) begin
                    if (w_misaligned) begin
                        misalign_d = 1'b1;
                        unpause_d  = 1'b1;
                        consumed_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = ex_mem_write;
                        bus_addr_d  = {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_wdata_d = w_st_wdata;
                        bus_wstrb_d = w_st_wstrb;
                        is_load_d   = !ex_mem_write;
                        lane_d      = ex_addr[1:0];
                        funct3_d    = ex_funct3;
                        rd_d        = ex_rd;
                    end
                end else if (!w_mem_op && !pause) begin
                    wb_valid_d = ex_valid;
                    wb_we_d    = ex_reg_write;
                    wb_rd_d    = ex_rd;
                    wb_data_d  = w_alu_result;
                end
            end
            ACCESS: begin
                // An ack on the last counted cycle takes priority over the timeout.
                if (bus_ack) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    unpause_d  = 1'b1;
                    consumed_d = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_we_d    = is_load_q;
                    wb_rd_d    = rd_q;
                    if (is_load_q) begin
                        wb_data_d = w_load;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    unpause_d  = 1'b1;
                    consumed_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + C_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            consumed_q  <= 1'b0;
            tmo_q       <= '0;
            is_load_q   <= 1'b0;
            lane_q      <= 2'b00;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'b0000;
            unpause_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            consumed_q  <= consumed_d;
            tmo_q       <= tmo_d;
            is_load_q   <= is_load_d;
            lane_q      <= lane_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            unpause_q   <= unpause_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req            = bus_req_q;
    assign bus_we             = bus_we_q;
    assign bus_addr           = bus_addr_q;
    assign bus_wdata          = bus_wdata_q;
    assign bus_wstrb          = bus_wstrb_q;
    assign mem_unpause_signal = unpause_q;
    assign wb_valid           = wb_valid_q;
    assign wb_we              = wb_we_q;
    assign wb_rd              = wb_rd_q;
    assign wb_data            = wb_data_q;
    assign misalign           = misalign_q;
    assign bus_err            = bus_err_q;
    assign busy               = (state_q == ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_lsu                                                               |
// | Directed load/store vectors checked against a behavioural model.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam int AW  = 32;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        mem_unpause_signal, wb_valid, wb_we, misalign, bus_err, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pause(pause),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_unpause_signal(mem_unpause_signal),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign), .bus_err(bus_err), .busy(busy)
    );

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int sz_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int n;
        int off;
        n   = sz_of(f3);
        off = int'(a[1:0]);
        s   = '0;
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        int n;
        n = sz_of(f3);
        d = '0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
        longint v;
        int n;
        int off;
        n   = sz_of(f3);
        off = int'(a[1:0]);
        v   = longint'(rw >> (8*off)) % (longint'(1) << (8*n));
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    int          m_wait = -1;   // ACCESS cycles already spent; -1 when nothing outstanding
    bit          m_cons = 1'b0;
    bit          m_done;
    bit          m_is_load;
    logic [2:0]  m_f3;
    logic [31:0] m_a;
    logic [4:0]  m_rd;
    bit          e_req, e_we, e_unp, e_mis, e_err, e_wbv, e_wbwe, e_wbd_chk;
    logic [31:0] e_addr, e_wdata, e_wbdata;
    logic [3:0]  e_strb;
    logic [4:0]  e_wbrd;

    always @(posedge clk) begin
        if (rst) begin
            m_wait = -1; m_cons = 1'b0;
            e_req = 1'b0; e_unp = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_wbv = 1'b0;
        end else begin
            m_done = 1'b0;
            e_unp = 1'b0; e_mis = 1'b0; e_err = 1'b0;
            e_wbv = 1'b0; e_wbwe = 1'b0; e_wbd_chk = 1'b0;
            if (m_wait >= 0) begin
                if (bus_ack) begin
                    m_done = 1'b1; e_wbv = 1'b1; e_wbwe = m_is_load; e_wbrd = m_rd;
                    e_wbd_chk = m_is_load; e_wbdata = m_load(m_f3, m_a, bus_rdata);
                end else if (m_wait + 1 == TMO) begin
                    m_done = 1'b1; e_err = 1'b1;
                end else begin
                    m_wait++;
                end
                if (m_done) begin
                    m_wait = -1; e_req = 1'b0; e_unp = 1'b1;
                end
            end else if (ex_valid && (ex_mem_read || ex_mem_write) && !m_cons) begin
                if (int'(ex_addr[1:0]) % sz_of(ex_funct3) != 0) begin
                    m_done = 1'b1; e_unp = 1'b1; e_mis = 1'b1;
                end else begin
                    m_wait = 0; e_req = 1'b1; e_we = ex_mem_write;
                    e_addr  = ex_addr - 32'(ex_addr[1:0]);
                    e_strb  = ex_mem_write ? m_strb(ex_funct3, ex_addr) : 4'b0000;
                    e_wdata = m_wdata(ex_funct3, ex_wdata);
                    m_is_load = !ex_mem_write; m_f3 = ex_funct3; m_a = ex_addr; m_rd = ex_rd;
                end
            end else if (!(ex_mem_read || ex_mem_write) && !pause) begin
                e_wbv = ex_valid; e_wbwe = ex_reg_write; e_wbrd = ex_rd;
                e_wbdata = ex_addr; e_wbd_chk = 1'b1;
            end
            if (m_done) m_cons = 1'b1;
            else if (!pause) m_cons = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk_b("rst.bus_req", bus_req, 1'b0);
            chk_b("rst.busy", busy, 1'b0);
            chk_b("rst.unpause", mem_unpause_signal, 1'b0);
            chk_b("rst.wb_valid", wb_valid, 1'b0);
            chk_b("rst.misalign", misalign, 1'b0);
            chk_b("rst.bus_err", bus_err, 1'b0);
        end else begin
            chk_b("m.bus_req", bus_req, e_req);
            chk_b("m.busy", busy, e_req);
            chk_b("m.unpause", mem_unpause_signal, e_unp);
            chk_b("m.misalign", misalign, e_mis);
            chk_b("m.bus_err", bus_err, e_err);
            chk_b("m.wb_valid", wb_valid, e_wbv);
            if (e_req) begin
                chk_b("m.bus_we", bus_we, e_we);
                chk_w("m.bus_addr", bus_addr, e_addr);
                chk_w("m.bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
                if (e_we) chk_w("m.bus_wdata", bus_wdata, e_wdata);
            end
            if (e_wbv) begin
                chk_b("m.wb_we", wb_we, e_wbwe);
                chk_w("m.wb_rd", 32'(wb_rd), 32'(e_wbrd));
                if (e_wbd_chk) chk_w("m.wb_data", wb_data, e_wbdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic v, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                          input logic rw);
        ex_valid = v; ex_mem_read = rd_op; ex_mem_write = wr_op; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = rdi; ex_reg_write = rw;
    endtask

    task automatic bubble();
        set_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // One memory op; ack raised in ACCESS cycle ack_at. x_val is store data or load result.
    task automatic run_mem(input string nm, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                           input int ack_at, input logic [3:0] x_strb, input logic [31:0] x_val);
        int n;
        set_ex(1'b1, ~wr, wr, f3, a, wd, 5'd3, ~wr);
        pause = 1'b1; bus_ack = 1'b0; bus_rdata = rdw;
        tick();
        chk_b({nm, ".req"}, bus_req, 1'b1);
        chk_b({nm, ".we"}, bus_we, wr);
        chk_w({nm, ".addr"}, bus_addr, {a[31:2], 2'b00});
        chk_w({nm, ".strb"}, 32'(bus_wstrb), 32'(x_strb));
        if (wr) chk_w({nm, ".wdata"}, bus_wdata, x_val);
        n = 1;
        while (mem_unpause_signal !== 1'b1 && n <= 20) begin
            bus_ack = (n == ack_at);
            tick();
            n++;
        end
        bus_ack = 1'b0;
        chk_w({nm, ".latency"}, 32'(n), 32'(ack_at + 1));
        chk_b({nm, ".wb_valid"}, wb_valid, 1'b1);
        chk_b({nm, ".wb_we"}, wb_we, ~wr);
        if (!wr) chk_w({nm, ".wb_data"}, wb_data, x_val);
        pause = 1'b0;
        bubble();
        tick();
        chk_b({nm, ".pulse_len"}, mem_unpause_signal, 1'b0);
    endtask

    initial begin
        int n_req;
        int n_err;
        int err_at;
        rst = 1'b1; pause = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
        bubble();
        repeat (2) tick();
        chk_b("reset.bus_req", bus_req, 1'b0);
        chk_b("reset.busy", busy, 1'b0);
        chk_b("reset.wb_valid", wb_valid, 1'b0);
        chk_b("reset.unpause", mem_unpause_signal, 1'b0);
        rst = 1'b0;
        tick();

        run_mem("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_FFFF, 3, 4'b0000, 32'hFFFF_FF80);
        run_mem("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         1, 4'b1100, 32'hABCD_ABCD);
        run_mem("lhu", 1'b0, 3'b101, 32'h0000_4002, 32'h0,         32'h8001_0000, 1, 4'b0000, 32'h0000_8001);
        run_mem("sb",  1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 32'h0,         2, 4'b0010, 32'hA5A5_A5A5);
        run_mem("lh",  1'b0, 3'b001, 32'h0000_7002, 32'h0,         32'h8001_1234, 1, 4'b0000, 32'hFFFF_8001);
        run_mem("lbu", 1'b0, 3'b100, 32'h0000_7001, 32'h0,         32'h0000_9100, 2, 4'b0000, 32'h0000_0091);
        run_mem("lbp", 1'b0, 3'b000, 32'h0000_7000, 32'h0,         32'h0000_007F, 1, 4'b0000, 32'h0000_007F);
        run_mem("lw3", 1'b0, 3'b011, 32'h0000_7004, 32'h0,         32'hCAFE_F00D, 1, 4'b0000, 32'hCAFE_F00D);
        run_mem("sw",  1'b1, 3'b010, 32'h0000_7008, 32'h1122_3344, 32'h0,         1, 4'b1111, 32'h1122_3344);

        // Non-memory op passthrough, then a paused bubble.
        set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd9, 1'b1);
        pause = 1'b0;
        tick();
        chk_b("alu.wb_valid", wb_valid, 1'b1);
        chk_w("alu.wb_data", wb_data, 32'h0000_0055);
        chk_w("alu.wb_rd", 32'(wb_rd), 32'd9);
        pause = 1'b1;
        tick();
        chk_b("alu.paused_bubble", wb_valid, 1'b0);
        pause = 1'b0;
        bubble();

        // Stray ack with no request outstanding.
        bus_ack = 1'b1;
        tick();
        tick();
        chk_b("idle_ack.unpause", mem_unpause_signal, 1'b0);
        chk_b("idle_ack.req", bus_req, 1'b0);
        bus_ack = 1'b0;

        // Misaligned word load.
        set_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd4, 1'b1);
        pause = 1'b1;
        tick();
        chk_b("mis.misalign", misalign, 1'b1);
        chk_b("mis.unpause", mem_unpause_signal, 1'b1);
        chk_b("mis.wb_valid", wb_valid, 1'b0);
        chk_b("mis.req", bus_req, 1'b0);
        tick();
        chk_b("mis.pulse_len", misalign, 1'b0);
        chk_b("mis.no_req", bus_req, 1'b0);
        pause = 1'b0;
        bubble();
        tick();

        // Store with no ack: timeout, then no reissue while paused.
        set_ex(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hDEAD_BEEF, 5'd0, 1'b0);
        pause = 1'b1;
        n_req = 0; n_err = 0; err_at = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_req === 1'b1) n_req++;
            if (bus_err === 1'b1) begin
                n_err++;
                if (err_at < 0) err_at = i;
            end
        end
        chk_w("tmo.req_cycles", 32'(n_req), 32'd4);
        chk_w("tmo.err_cycle", 32'(err_at), 32'd4);
        chk_w("tmo.err_count", 32'(n_err), 32'd1);
        pause = 1'b0;
        tick();
        chk_b("tmo.clear_no_req", bus_req, 1'b0);
        pause = 1'b1;
        tick();
        chk_b("tmo.reissue", bus_req, 1'b1);
        tick();

        // Asynchronous reset in the middle of the access.
        rst = 1'b1;
        #1;
        chk_b("arst.bus_req", bus_req, 1'b0);
        chk_b("arst.busy", busy, 1'b0);
        chk_b("arst.wb_valid", wb_valid, 1'b0);
        chk_b("arst.unpause", mem_unpause_signal, 1'b0);
        bubble();
        pause = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b("arst.no_pulse", mem_unpause_signal, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-access stage of the 5-stage pipeline. Takes load/store requests from the EX/MEM register and runs them on a single-outstanding valid/ack data bus. It handles byte/half/word alignment, sign extension and misalignment, and drives the writeback bundle. It raises mem_unpause_signal toward the pipeline controller when an access finishes, which releases the pause the ID stage set for the memory op.

Parameters:
ADDR_WIDTH, 32, byte-address width of ex_addr/bus_addr
TIMEOUT, 255, max cycles bus_req held without bus_ack before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset
pause  in  1  global pipeline pause from controller
ex_valid  in  1  EX/MEM register holds valid instruction
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_addr  in  ADDR_WIDTH  effective address (ALU result for non-memory ops)
ex_wdata  in  32  store data
ex_rd  in  5  destination register
ex_reg_write  in  1  instruction writes rd
bus_req  out  1  bus request
bus_we  out  1  1=write
bus_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=0
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte enables (0 on reads)
bus_ack  in  1  access complete; bus_rdata valid for reads
bus_rdata  in  32  read word
mem_unpause_signal  out  1  1-cycle completion pulse
wb_valid  out  1  writeback bundle valid
wb_we  out  1  writeback register-write enable
wb_rd  out  5  writeback destination
wb_data  out  32  writeback data
misalign  out  1  1-cycle misaligned-access pulse
bus_err  out  1  1-cycle timeout pulse
busy  out  1  state==ACCESS

Behaviour:
- Reset: rst async active-high; reset clk domain clk. All outputs 0, state IDLE, consumed=0, timeout counter=0. Reset mid-access drops bus_req immediately; no completion pulse.
- Memory op = ex_mem_read|ex_mem_write. If both are high, it is a store. funct3 011/110/111 is treated as W (unsigned irrelevant for W).
- Capture condition: IDLE && ex_valid && memory op && !consumed.
- consumed: set on any completion (ack, misalign, timeout). Cleared on any clock edge where pause=0. This prevents re-executing an op held in EX/MEM by pause.
- States: IDLE, ACCESS. Outputs are registered.
- IDLE, capture, aligned: next cycle state=ACCESS and bus_req=1.
  - bus_addr = {ex_addr[ADDR_WIDTH-1:2],2'b00}; bus_we = store.
  - Store B: wdata = byte×4, wstrb = 0001<<addr[1:0].
  - Store H: wdata = half×2, wstrb = addr[1] ? 1100 : 0011.
  - Store W: wstrb = 1111.
  - Loads: wstrb = 0000.
  - addr[1:0], funct3, rd and the read/write kind are latched.
- IDLE, capture, misaligned (H with addr[0]=1; W with addr[1:0]≠0): no bus_req. Next cycle misalign=1, mem_unpause_signal=1, wb_valid=0, consumed set, stay IDLE.
- ACCESS: bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb held stable until bus_ack is sampled high. Then next cycle:
  - bus_req=0, state IDLE, mem_unpause_signal=1, consumed set.
  - Load: wb_valid=1, wb_we=1, wb_rd=latched rd, wb_data = lane selected by latched addr[1:0]. B/H are sign-extended, BU/HU zero-extended.
  - Store: wb_valid=1, wb_we=0.
  - Ack in the first ACCESS cycle is legal (one-cycle access gives 2-cycle capture-to-unpause latency).
- Timeout: counter increments each ACCESS cycle and is cleared on leaving ACCESS. If TIMEOUT cycles elapse without ack, next cycle: bus_req=0, bus_err=1, mem_unpause_signal=1, wb_valid=0, consumed set, IDLE. An ack coinciding with the final counted cycle wins over timeout.
- bus_ack while bus_req=0 is ignored.
- Non-memory op, IDLE, pause=0: next cycle wb_valid=ex_valid, wb_we=ex_reg_write, wb_rd=ex_rd, wb_data=ex_addr. With pause=1 and no completion, next cycle wb_valid=0 (bubble).
- Pulses (mem_unpause_signal, misalign, bus_err) last exactly one cycle and never assert together with a new bus_req.
- System contract: upstream keeps EX/MEM stable while busy=1. The ID stage pauses for every memory op.

Test Plan:
- Reset: assert rst mid-ACCESS -> bus_req, busy, wb_valid, mem_unpause_signal all 0 the same cycle; no pulse after release.
- LB at addr 0x1003, bus_rdata=0x80FF_FFFF, ack after 3 cycles -> bus_addr=0x1000, wstrb=0000; one cycle later wb_data=0xFFFF_FF80, wb_we=1, one unpause pulse.
- SH at 0x2002, ex_wdata=0x1234_ABCD, ack on first cycle -> bus_wdata=0xABCD_ABCD, bus_wstrb=1100, bus_we=1; unpause 2 cycles after capture; wb_we=0.
- LW at 0x3001 -> no bus_req ever; misalign=1 and mem_unpause_signal=1 for exactly one cycle; wb_valid=0.
- TIMEOUT=4, SW with no ack -> bus_req high exactly 4 cycles, then bus_err=1 and unpause=1 one cycle; with pause held and ex_valid still 1, no second bus_req until a pause=0 cycle.
- LHU at 0x4002, rdata=0x8001_0000 -> wb_data=0x0000_8001. Then ALU op ex_addr=0x55 with pause=0 -> next cycle wb_valid=1, wb_data=0x55.
